// File: rtl/tof_pll_prog_arb_pkg.sv
// rtl/tof_pll_prog_arb_pkg.sv - shared types and constants for the PLL programming arbiter
package tof_pll_pkg;

    localparam int DEFAULT_WORD_BITS = 32;

    localparam logic GNT_INIT = 1'b0;
    localparam logic GNT_HOST = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT_LO,
        ST_SHIFT_HI,
        ST_LOAD,
        ST_GAP
    } pll_state_t;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_FRAME,
        ARB_GAP
    } arb_state_t;

endpackage

// File: rtl/tof_pll_prog_arb_if.sv
// rtl/tof_pll_prog_arb_if.sv - word/ack/done handshake of the two PLL word requesters
interface tof_pll_prog_arb_if
    import tof_pll_pkg::*;
#(
    parameter int WORD_BITS = DEFAULT_WORD_BITS
);
    logic                 init_req_i;
    logic [WORD_BITS-1:0] init_word_i;
    logic                 init_ack_o;
    logic                 init_done_o;
    logic                 host_req_i;
    logic [WORD_BITS-1:0] host_word_i;
    logic                 host_ack_o;
    logic                 host_done_o;

    modport master (
        output init_req_i, init_word_i, host_req_i, host_word_i,
        input  init_ack_o, init_done_o, host_ack_o, host_done_o
    );

    modport slave (
        input  init_req_i, init_word_i, host_req_i, host_word_i,
        output init_ack_o, init_done_o, host_ack_o, host_done_o
    );
endinterface

// File: rtl/tof_pll_prog_arb_shifter.sv
// rtl/tof_pll_prog_arb_shifter.sv - SHIFT/LOAD timing engine driving the PLL serial pins
module tof_pll_shifter
    import tof_pll_pkg::*;
#(
    parameter int WORD_BITS   = DEFAULT_WORD_BITS,
    parameter int SCLK_DIV    = 4,
    parameter int LOAD_CYCLES = 8
) (
    input  logic                 clk200,
    input  logic                 rst200_n,
    input  logic                 start,
    input  logic [WORD_BITS-1:0] word,
    output logic                 done,
    output logic                 pll_sclk,
    output logic                 pll_sdin,
    output logic                 pll_load
);
    localparam int                CNT_W    = $clog2(WORD_BITS + 1);
    localparam logic [7:0]        DIV      = 8'(SCLK_DIV);
    localparam logic [7:0]        LDC      = 8'(LOAD_CYCLES);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WORD_BITS - 1);

    pll_state_t           state, state_nxt;
    logic [7:0]           phase, phase_nxt;
    logic [CNT_W-1:0]     bit_cnt;
    logic [WORD_BITS-1:0] sreg;
    logic                 phase_end;
    logic                 capture;
    logic                 shift;

    assign phase_end = (phase == 8'd1);

    always_ff @(posedge clk200 or negedge rst200_n) begin
        if (!rst200_n) begin
            state <= ST_IDLE;
            phase <= 8'd0;
        end else begin
            state <= state_nxt;
            phase <= phase_nxt;
        end
    end

    always_ff @(posedge clk200 or negedge rst200_n) begin
        if (!rst200_n) begin
            sreg    <= '0;
            bit_cnt <= '0;
        end else if (capture) begin
            sreg    <= word;
            bit_cnt <= '0;
        end else if (shift) begin
            sreg    <= {sreg[WORD_BITS-2:0], 1'b0};
            bit_cnt <= bit_cnt + 1'b1;
        end
    end

    // Data advances only on the last high cycle, so sdin moves together with the sclk fall.
    always_comb begin
        state_nxt = state;
        phase_nxt = phase;
        capture   = 1'b0;
        shift     = 1'b0;
        done      = 1'b0;
        pll_sclk  = 1'b0;
        pll_sdin  = 1'b0;
        pll_load  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    capture   = 1'b1;
                    state_nxt = ST_SHIFT_LO;
                    phase_nxt = DIV;
                end
            end
            ST_SHIFT_LO: begin
                pll_sdin = sreg[WORD_BITS-1];
                if (phase_end) begin
                    state_nxt = ST_SHIFT_HI;
                    phase_nxt = DIV;
                end else begin
                    phase_nxt = phase - 8'd1;
                end
            end
            ST_SHIFT_HI: begin
                pll_sclk = 1'b1;
                pll_sdin = sreg[WORD_BITS-1];
                if (phase_end) begin
                    shift = 1'b1;
                    if (bit_cnt == LAST_BIT) begin
                        state_nxt = ST_LOAD;
                        phase_nxt = LDC;
                    end else begin
                        state_nxt = ST_SHIFT_LO;
                        phase_nxt = DIV;
                    end
                end else begin
                    phase_nxt = phase - 8'd1;
                end
            end
            ST_LOAD: begin
                pll_load = 1'b1;
                if (phase_end) begin
                    done      = 1'b1;
                    state_nxt = ST_IDLE;
                    phase_nxt = 8'd0;
                end else begin
                    phase_nxt = phase - 8'd1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                phase_nxt = 8'd0;
            end
        endcase
    end
endmodule

// File: rtl/tof_pll_prog_arb.sv
// rtl/tof_pll_prog_arb.sv - round-robin arbiter sharing the PLL serial programming port
module tof_pll_prog_arb
    import tof_pll_pkg::*;
#(
    parameter int WORD_BITS   = DEFAULT_WORD_BITS,
    parameter int SCLK_DIV    = 4,
    parameter int LOAD_CYCLES = 8,
    parameter int GAP_CYCLES  = 2
) (
    input  logic               clk200_i,
    input  logic               rst200_n_i,
    tof_pll_prog_arb_if.slave  req_if,
    input  logic               hold_i,
    output logic               busy_o,
    output logic               pll_sclk_o,
    output logic               pll_sdin_o,
    output logic               pll_load_o
);
    localparam logic [7:0] GAPC = 8'(GAP_CYCLES);

    arb_state_t           state, state_nxt;
    logic [7:0]           gap_cnt, gap_nxt;
    logic                 gnt_id;
    logic                 pref_host;
    logic                 grant;
    logic                 grant_host;
    logic                 rr_update;
    logic                 eng_done;
    logic [WORD_BITS-1:0] gnt_word;

    always_ff @(posedge clk200_i or negedge rst200_n_i) begin
        if (!rst200_n_i) begin
            state     <= ARB_IDLE;
            gap_cnt   <= 8'd0;
            gnt_id    <= GNT_INIT;
            pref_host <= 1'b0;
        end else begin
            state   <= state_nxt;
            gap_cnt <= gap_nxt;
            if (grant) begin
                gnt_id <= grant_host;
            end
            if (rr_update) begin
                pref_host <= (gnt_id == GNT_INIT);
            end
        end
    end

    // Reset gates the grant so the combinational ack stays low while reset is held.
    always_comb begin
        state_nxt  = state;
        gap_nxt    = gap_cnt;
        grant      = 1'b0;
        grant_host = 1'b0;
        rr_update  = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (rst200_n_i && !hold_i && (req_if.init_req_i || req_if.host_req_i)) begin
                    grant      = 1'b1;
                    grant_host = req_if.host_req_i && (!req_if.init_req_i || pref_host);
                    state_nxt  = ARB_FRAME;
                end
            end
            ARB_FRAME: begin
                if (eng_done) begin
                    state_nxt = ARB_GAP;
                    gap_nxt   = GAPC;
                end
            end
            ARB_GAP: begin
                if (gap_cnt == 8'd1) begin
                    state_nxt = ARB_IDLE;
                    gap_nxt   = 8'd0;
                    rr_update = 1'b1;
                end else begin
                    gap_nxt = gap_cnt - 8'd1;
                end
            end
            default: begin
                state_nxt = ARB_IDLE;
                gap_nxt   = 8'd0;
            end
        endcase
    end

    assign gnt_word = grant_host ? req_if.host_word_i : req_if.init_word_i;

    tof_pll_shifter #(
        .WORD_BITS   (WORD_BITS),
        .SCLK_DIV    (SCLK_DIV),
        .LOAD_CYCLES (LOAD_CYCLES)
    ) u_shifter (
        .clk200   (clk200_i),
        .rst200_n (rst200_n_i),
        .start    (grant),
        .word     (gnt_word),
        .done     (eng_done),
        .pll_sclk (pll_sclk_o),
        .pll_sdin (pll_sdin_o),
        .pll_load (pll_load_o)
    );

    assign req_if.init_ack_o  = grant && (grant_host == GNT_INIT);
    assign req_if.host_ack_o  = grant && (grant_host == GNT_HOST);
    assign req_if.init_done_o = eng_done && (gnt_id == GNT_INIT);
    assign req_if.host_done_o = eng_done && (gnt_id == GNT_HOST);
    assign busy_o             = (state != ARB_IDLE) || grant;
endmodule

// File: tb/tb_tof_pll_prog_arb.sv
// tb/tb_tof_pll_prog_arb.sv - scoreboard bench for the PLL programming arbiter
`timescale 1ns/100ps
module tb_tof_pll_prog_arb;
    import tof_pll_pkg::*;

    localparam int WB = 32;

    function automatic int sd_of(input int d);
        return (d == 0) ? 4 : 1;
    endfunction
    function automatic int ld_of(input int d);
        return (d == 0) ? 8 : 1;
    endfunction
    function automatic int gp_of(input int d);
        return (d == 0) ? 2 : 1;
    endfunction
    function automatic int frame_of(input int d);
        return 1 + 2 * sd_of(d) * WB + ld_of(d) + gp_of(d);
    endfunction

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          hold  = 1'b0;
    logic [1:0]    ireq  = 2'b00;
    logic [1:0]    hreq  = 2'b00;
    logic [WB-1:0] iword [2];
    logic [WB-1:0] hword [2];
    logic [1:0]    sclk, sdin, load, busy;

    tof_pll_prog_arb_if #(.WORD_BITS(WB)) rif0 ();
    tof_pll_prog_arb_if #(.WORD_BITS(WB)) rif1 ();

    assign rif0.init_req_i  = ireq[0];
    assign rif0.host_req_i  = hreq[0];
    assign rif0.init_word_i = iword[0];
    assign rif0.host_word_i = hword[0];
    assign rif1.init_req_i  = ireq[1];
    assign rif1.host_req_i  = hreq[1];
    assign rif1.init_word_i = iword[1];
    assign rif1.host_word_i = hword[1];

    wire [1:0] iack  = {rif1.init_ack_o,  rif0.init_ack_o};
    wire [1:0] hack  = {rif1.host_ack_o,  rif0.host_ack_o};
    wire [1:0] idone = {rif1.init_done_o, rif0.init_done_o};
    wire [1:0] hdone = {rif1.host_done_o, rif0.host_done_o};

    tof_pll_prog_arb #(.WORD_BITS(WB)) dut0 (
        .clk200_i   (clk),
        .rst200_n_i (rst_n),
        .req_if     (rif0),
        .hold_i     (hold),
        .busy_o     (busy[0]),
        .pll_sclk_o (sclk[0]),
        .pll_sdin_o (sdin[0]),
        .pll_load_o (load[0])
    );

    tof_pll_prog_arb #(.WORD_BITS(WB), .SCLK_DIV(1), .LOAD_CYCLES(1), .GAP_CYCLES(1)) dut1 (
        .clk200_i   (clk),
        .rst200_n_i (rst_n),
        .req_if     (rif1),
        .hold_i     (hold),
        .busy_o     (busy[1]),
        .pll_sclk_o (sclk[1]),
        .pll_sdin_o (sdin[1]),
        .pll_load_o (load[1])
    );

    always #2.5 clk = ~clk;

    typedef struct {
        bit            id;
        logic [WB-1:0] word;
        int            acyc;
    } exp_t;

    exp_t          exp_q [2][$];
    int            cyc = 0;
    int            n_checks = 0;
    int            n_pass = 0;
    int            tmo = 0;
    bit            fin_req = 1'b0;
    bit            fin_done = 1'b0;
    int            free_cyc [2];
    int            blen [2];
    int            nacks [2];
    int            rises [2];
    int            loadc [2];
    int            glitch [2];
    int            badper [2];
    int            last_rise [2];
    bit            pref_host [2];
    logic          prev_sclk [2];
    logic          prev_sdin [2];
    logic          prev_busy [2];
    logic [WB-1:0] bits [2];

    task automatic check(input string nm, input int d, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s dut%0d: got 0x%0h want 0x%0h (cycle %0d)", nm, d, act, exp, cyc);
        end
    endtask

    task automatic clear_frame(input int d);
        rises[d]  = 0;
        loadc[d]  = 0;
        glitch[d] = 0;
        badper[d] = 0;
        bits[d]   = '0;
    endtask

    task automatic mon(input int d);
        logic exp_any;
        logic exp_id;
        exp_t e;
        if (!rst_n) begin
            check("reset_outputs", d,
                  64'({iack[d], hack[d], idone[d], hdone[d], busy[d], sclk[d], sdin[d], load[d]}), 64'd0);
            exp_q[d].delete();
            free_cyc[d]  = 0;
            pref_host[d] = 1'b0;
            blen[d]      = 0;
            nacks[d]     = 0;
            prev_sclk[d] = 1'b0;
            prev_sdin[d] = 1'b0;
            prev_busy[d] = 1'b0;
            clear_frame(d);
            return;
        end
        // The port is free one full frame after each grant; any pending request must then be granted.
        exp_any = !hold && (ireq[d] || hreq[d]) && (cyc >= free_cyc[d]);
        if (iack[d] || hack[d] || exp_any) begin
            check("ack_present", d, 64'(iack[d] | hack[d]), 64'(exp_any));
            if (iack[d] || hack[d]) begin
                exp_id = hreq[d] && (!ireq[d] || pref_host[d]);
                check("ack_single", d, 64'(iack[d] & hack[d]), 64'd0);
                check("ack_id", d, 64'(hack[d]), 64'(exp_id));
                e.id   = exp_id;
                e.word = exp_id ? hword[d] : iword[d];
                e.acyc = cyc;
                exp_q[d].push_back(e);
                free_cyc[d] = cyc + frame_of(d);
                nacks[d]++;
                clear_frame(d);
            end
        end
        if (sclk[d] && !prev_sclk[d]) begin
            if (rises[d] > 0 && (cyc - last_rise[d]) != 2 * sd_of(d)) badper[d]++;
            bits[d]      = {bits[d][WB-2:0], sdin[d]};
            rises[d]     = rises[d] + 1;
            last_rise[d] = cyc;
        end
        if (sclk[d] && prev_sclk[d] && (sdin[d] != prev_sdin[d])) glitch[d]++;
        if (load[d]) begin
            loadc[d]++;
            if (sclk[d] || sdin[d]) glitch[d]++;
        end
        if (idone[d] || hdone[d]) begin
            check("done_single", d, 64'(idone[d] & hdone[d]), 64'd0);
            check("done_expected", d, 64'(exp_q[d].size() != 0), 64'd1);
            if (exp_q[d].size() != 0) begin
                e = exp_q[d].pop_front();
                check("done_id", d, 64'(hdone[d]), 64'(e.id));
                check("frame_word", d, 64'(bits[d]), 64'(e.word));
                check("sclk_rises", d, 64'(rises[d]), 64'(WB));
                check("load_cycles", d, 64'(loadc[d]), 64'(ld_of(d)));
                check("done_latency", d, 64'(cyc - e.acyc), 64'(2 * sd_of(d) * WB + ld_of(d)));
                check("sdin_stable", d, 64'(glitch[d]), 64'd0);
                check("sclk_period", d, 64'(badper[d]), 64'd0);
                pref_host[d] = (e.id == 1'b0);
            end
        end
        if (!busy[d] && prev_busy[d]) begin
            check("busy_len", d, 64'(blen[d]), 64'(nacks[d] * frame_of(d)));
            blen[d]  = 0;
            nacks[d] = 0;
        end
        if (busy[d]) blen[d]++;
        prev_sclk[d] = sclk[d];
        prev_sdin[d] = sdin[d];
        prev_busy[d] = busy[d];
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        for (int d = 0; d < 2; d++) mon(d);
        if (fin_req && !fin_done) begin
            check("timeouts", 0, 64'(tmo), 64'd0);
            fin_done = 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input int d, input bit host, input bit drop, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (host ? hack[d] : iack[d]) begin
                tick();
                if (drop) begin
                    if (host) hreq[d] = 1'b0;
                    else      ireq[d] = 1'b0;
                end
                return;
            end
        end
        tmo++;
        $display("FAIL wait_ack dut%0d host=%0d: no ack within %0d cycles", d, host, budget);
    endtask

    task automatic wait_any_ack(input int d, input bit drop, input int budget);
        bit h;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (iack[d] || hack[d]) begin
                h = hack[d];
                tick();
                if (drop) begin
                    if (h) hreq[d] = 1'b0;
                    else   ireq[d] = 1'b0;
                end
                return;
            end
        end
        tmo++;
        $display("FAIL wait_any_ack dut%0d: no ack within %0d cycles", d, budget);
    endtask

    task automatic wait_done(input int d, input bit host, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (host ? hdone[d] : idone[d]) begin
                tick();
                return;
            end
        end
        tmo++;
        $display("FAIL wait_done dut%0d host=%0d: no done within %0d cycles", d, host, budget);
    endtask

    task automatic wait_idle(input int d, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy[d]) begin
                tick();
                return;
            end
        end
        tmo++;
        $display("FAIL wait_idle dut%0d: still busy after %0d cycles", d, budget);
    endtask

    task automatic wait_rises(input int d, input int n, input int budget);
        int seen;
        logic was;
        seen = 0;
        was  = sclk[d];
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (sclk[d] && !was) seen++;
            was = sclk[d];
            if (seen == n) return;
        end
        tmo++;
        $display("FAIL wait_rises dut%0d: saw %0d of %0d rises", d, seen, n);
    endtask

    initial begin
        int pat;
        for (int d = 0; d < 2; d++) begin
            iword[d] = '0;
            hword[d] = '0;
        end
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b1;

        iword[0] = 32'hA500_0001;
        ireq[0]  = 1'b1;
        wait_ack(0, 1'b0, 1'b1, 5);
        wait_done(0, 1'b0, 600);
        wait_idle(0, 20);

        // Fresh reset so the simultaneous pair starts from "init preferred".
        rst_n = 1'b0;
        tick();
        tick();
        rst_n    = 1'b1;
        iword[0] = $urandom;
        hword[0] = $urandom;
        ireq[0]  = 1'b1;
        hreq[0]  = 1'b1;
        wait_ack(0, 1'b0, 1'b1, 5);
        wait_ack(0, 1'b1, 1'b1, 600);
        wait_done(0, 1'b1, 600);

        iword[0] = $urandom;
        hword[0] = $urandom;
        ireq[0]  = 1'b1;
        hreq[0]  = 1'b1;
        for (int k = 0; k < 4; k++) wait_any_ack(0, 1'b0, 600);
        ireq[0] = 1'b0;
        hreq[0] = 1'b0;
        wait_idle(0, 600);

        hword[0] = $urandom;
        hreq[0]  = 1'b1;
        wait_ack(0, 1'b1, 1'b1, 5);
        repeat (99) tick();
        hold     = 1'b1;
        iword[0] = $urandom;
        ireq[0]  = 1'b1;
        wait_done(0, 1'b1, 600);
        repeat (50) tick();
        hold = 1'b0;
        wait_ack(0, 1'b0, 1'b1, 3);
        wait_done(0, 1'b0, 600);
        wait_idle(0, 20);

        iword[0] = $urandom;
        ireq[0]  = 1'b1;
        wait_ack(0, 1'b0, 1'b1, 5);
        hword[0] = $urandom;
        hreq[0]  = 1'b1;
        wait_rises(0, 11, 600);
        tick();
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        wait_ack(0, 1'b1, 1'b1, 3);
        wait_done(0, 1'b1, 600);
        wait_idle(0, 20);

        for (int k = 0; k < 4; k++) begin
            pat      = int'($urandom_range(1, 3));
            iword[0] = $urandom;
            hword[0] = $urandom;
            ireq[0]  = pat[0];
            hreq[0]  = pat[1];
            while (ireq[0] || hreq[0]) wait_any_ack(0, 1'b1, 600);
            wait_idle(0, 600);
        end

        iword[1] = 32'hFFFF_FFFF;
        ireq[1]  = 1'b1;
        wait_ack(1, 1'b0, 1'b1, 5);
        wait_done(1, 1'b0, 200);
        wait_idle(1, 10);
        iword[1] = $urandom;
        hword[1] = $urandom;
        ireq[1]  = 1'b1;
        hreq[1]  = 1'b1;
        while (ireq[1] || hreq[1]) wait_any_ack(1, 1'b1, 200);
        wait_idle(1, 200);

        fin_req = 1'b1;
        for (int i = 0; i < 5 && !fin_done; i++) @(posedge clk);
        @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
